// File: rtl/wb_led_slave.sv
// Wishbone pipelined slave driving six LEDs with a maskable blink phase.
// One request in flight at a time; ack/err arrive exactly one cycle after accept.
module wb_led_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PRESCALE  = 27000
) (
  input  logic        clk,
  input  logic        i_resetn,
  input  logic        i_wb_m2s_cyc,
  input  logic        i_wb_m2s_stb,
  input  logic        i_wb_m2s_we,
  input  logic [31:0] i_wb_m2s_addr,
  input  logic [31:0] i_wb_m2s_data,
  input  logic [3:0]  i_wb_m2s_sel,
  output logic        o_wb_s2m_ack,
  output logic        o_wb_s2m_stall,
  output logic        o_wb_s2m_err,
  output logic [31:0] o_wb_s2m_data,
  output logic [31:0] o_wb_s2m_err_addr,
  output logic [5:0]  o_leds
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [1:0] R_LED = 2'd0, R_MASK = 2'd1, R_PERIOD = 2'd2, R_STATUS = 2'd3;

  logic [5:0]    led_q, mask_q, leds_q;
  logic [15:0]   period_q, count_q;
  logic          phase_q;
  logic [PW-1:0] pre_q;
  logic          ack_q, err_q, stall_q;
  logic [31:0]   rdata_q, err_addr_q;

  logic        accept, hit, bad, wr, period_wr, tick;
  logic [1:0]  idx;
  logic [15:0] bmask;
  logic [31:0] cur;
  logic        unused_ok;

  assign accept    = i_wb_m2s_cyc && i_wb_m2s_stb && !stall_q;
  assign hit       = (i_wb_m2s_addr[31:4] == BASE_ADDR[31:4]) && (i_wb_m2s_addr[1:0] == 2'b00);
  assign idx       = i_wb_m2s_addr[3:2];
  assign bad       = !hit || (i_wb_m2s_we && idx == R_STATUS);
  assign wr        = accept && i_wb_m2s_we && !bad;
  assign period_wr = wr && idx == R_PERIOD;
  assign bmask     = {{8{i_wb_m2s_sel[1]}}, {8{i_wb_m2s_sel[0]}}};
  assign tick      = (pre_q == PW'(PRESCALE - 1));
  // Upper lanes only ever land on read-as-zero bits.
  assign unused_ok = ^{i_wb_m2s_data[31:16], i_wb_m2s_sel[3:2]};

  always_comb begin
    cur = '0;
    case (idx)
      R_LED:    cur = {26'd0, led_q};
      R_MASK:   cur = {26'd0, mask_q};
      R_PERIOD: cur = {16'd0, period_q};
      default:  cur = {count_q, 15'd0, phase_q};
    endcase
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      stall_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      led_q      <= '0;
      mask_q     <= '0;
      period_q   <= '0;
      leds_q     <= '0;
    end else begin
      stall_q <= accept;
      ack_q   <= accept && !bad;
      err_q   <= accept && bad;
      rdata_q <= (accept && !bad && !i_wb_m2s_we) ? cur : '0;
      if (accept && bad) err_addr_q <= i_wb_m2s_addr;
      if (wr && idx == R_LED)
        led_q <= (led_q & ~bmask[5:0]) | (i_wb_m2s_data[5:0] & bmask[5:0]);
      if (wr && idx == R_MASK)
        mask_q <= (mask_q & ~bmask[5:0]) | (i_wb_m2s_data[5:0] & bmask[5:0]);
      if (period_wr)
        period_q <= (period_q & ~bmask) | (i_wb_m2s_data[15:0] & bmask);
      leds_q <= led_q ^ (mask_q & {6{phase_q}});
    end
  end

  // Blink timebase; a PERIOD write restarts it from a clean phase.
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pre_q   <= '0;
      count_q <= '0;
      phase_q <= 1'b0;
    end else if (period_wr) begin
      pre_q   <= '0;
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (period_q == 16'd0) begin
        count_q <= '0;
        phase_q <= 1'b0;
      end else if (tick) begin
        if (count_q == period_q - 16'd1) begin
          count_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

  // A master that drops cyc abandons the response.
  assign o_wb_s2m_ack      = ack_q && i_wb_m2s_cyc;
  assign o_wb_s2m_err      = err_q && i_wb_m2s_cyc;
  assign o_wb_s2m_stall    = stall_q;
  assign o_wb_s2m_data     = o_wb_s2m_ack ? rdata_q : '0;
  assign o_wb_s2m_err_addr = err_addr_q;
  assign o_leds            = leds_q;
endmodule

// File: doc/wb_led_slave.md
WB_LED_SLAVE -- requirements
Module: wb_led_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, 16-byte-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE, default 27000, clk cycles per blink tick (1 ms at 27 MHz); legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port i_resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports i_wb_m2s_cyc, i_wb_m2s_stb, i_wb_m2s_we, each input, 1, Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have ports i_wb_m2s_addr and i_wb_m2s_data, input, 32 each, byte address and write data; i_wb_m2s_sel, input, 4, byte lane enables.
REQ-007 SHALL have ports o_wb_s2m_ack, o_wb_s2m_stall, o_wb_s2m_err, output, 1 each, and o_wb_s2m_data and o_wb_s2m_err_addr, output, 32 each.
REQ-008 SHALL have port o_leds, output, 6, active-high LED drive; board inversion is done outside this block.

Function
REQ-009 SHALL accept a request on a clk edge where i_wb_m2s_cyc && i_wb_m2s_stb && !o_wb_s2m_stall.
REQ-010 SHALL assert o_wb_s2m_stall for exactly the cycle after each accept, giving at most one outstanding request; otherwise stall is low.
REQ-011 SHALL assert exactly one of ack or err for exactly one cycle, on the cycle after accept; never both at once; latency fixed at 1.
REQ-012 SHALL suppress the response and discard pending read data if i_wb_m2s_cyc is low in the response cycle; a write already applied is not undone.
REQ-013 SHALL decode a request as mapped when addr[31:4] == BASE_ADDR[31:4] and addr[1:0] == 2'b00; register index is addr[3:2].
REQ-014 SHALL provide register map: 0x0 LED[5:0] RW; 0x4 MASK[5:0] RW; 0x8 PERIOD[15:0] RW; 0xC STATUS RO, where bit0 = phase and [31:16] = blink count.
REQ-015 SHALL apply writes per byte lane using sel; unimplemented bits read 0 and ignore writes.
REQ-016 SHALL respond with err, and leave all register state unchanged, for an unmapped address, a misaligned address, or a write to STATUS.
REQ-017 SHALL latch the accepted address into o_wb_s2m_err_addr on every err response and hold it until the next error.
REQ-018 SHALL present read data on o_wb_s2m_data in the ack cycle; o_wb_s2m_data SHALL be 0 in all other cycles, including write acks and errs.
REQ-019 SHALL run the prescaler 0..PRESCALE-1 continuously, producing a one-cycle tick when it wraps.
REQ-020 SHALL, on each tick with PERIOD != 0, increment count; when count == PERIOD-1 at a tick, count wraps to 0 and phase toggles.
REQ-021 SHALL hold count and phase at 0 while PERIOD == 0.
REQ-022 SHALL, on any write to PERIOD, clear count, phase and the prescaler; the write takes priority over a same-cycle tick or toggle.
REQ-023 SHALL register o_leds = LED ^ (MASK & {6{phase}}), updating one cycle after any change to LED, MASK or phase.
REQ-024 SHALL let a LED or MASK write and a phase toggle in the same cycle both take effect.

Reset
REQ-025 SHALL clear asynchronously, while i_resetn is low, LED, MASK, PERIOD, count, phase, prescaler, o_leds, ack, err, stall, o_wb_s2m_data and o_wb_s2m_err_addr to 0.
REQ-026 SHALL drop any in-flight response when reset asserts mid-transaction; the first accept after release is a fresh request.

Verification
REQ-027 SHALL pass: write 0x8000_0000 = 0x2A with sel=0xF -> ack one cycle later, stall high that cycle, o_leds = 6'b101010 the following cycle; read back returns 0x0000_002A.
REQ-028 SHALL pass: write 0x8000_0000 = 0xFFFF_FF3F with sel=0x2 -> LED unchanged (byte 1 only); then sel=0x1 -> LED = 0x3F.
REQ-029 SHALL pass with PRESCALE=4: MASK=0x01, PERIOD=2 -> phase toggles every 8 clk; o_leds[0] toggles; writing PERIOD=0 forces phase 0 and count 0.
REQ-030 SHALL pass: read 0x8000_0010, write 0x8000_000C, and read 0x8000_0002 -> each gets err (no ack), err_addr equals that address, and no register changes.
REQ-031 SHALL pass: back-to-back stb held high for two writes -> second is accepted only after the stall cycle; two acks arrive, 2 cycles apart.
REQ-032 SHALL pass: assert i_resetn low in the stall cycle of a read -> no ack, all outputs 0 immediately; after release, a read of LED returns 0.
